// File: rtl/if_stage_fetch_pkg.sv
// Shared widths, bubble encoding and fetch FSM state encoding for the fetch stage
// and the inter-stage pipeline registers.
package if_stage_fetch_pkg;

    localparam int unsigned ADDRESS_LEN     = 32;
    localparam int unsigned INSTRUCTION_LEN = 32;

    // A bubble is an all-zero instruction word with valid cleared.
    localparam logic [INSTRUCTION_LEN-1:0] BUBBLE_INSTR = '0;
    localparam logic                       BUBBLE_VALID = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_stage_fetch_if_id_reg.sv
// Generic inter-stage register: flush inserts a bubble and beats freeze, freeze holds.
module if_id_pipeline_reg
    import if_stage_fetch_pkg::*;
#(
    parameter int unsigned PcWidth    = ADDRESS_LEN,
    parameter int unsigned InstrWidth = INSTRUCTION_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  freeze_i,
    input  logic [PcWidth-1:0]    pc_i,
    input  logic [InstrWidth-1:0] instr_i,
    input  logic                  valid_i,
    output logic [PcWidth-1:0]    pc_o,
    output logic [InstrWidth-1:0] instr_o,
    output logic                  valid_o
);

    logic [PcWidth-1:0]    pc_q, pc_d;
    logic [InstrWidth-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = '0;
            valid_d = BUBBLE_VALID;
        end else if (!freeze_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to instruction memory
// and feeds decode through the IF/ID register, honouring freeze and branch redirects.
module if_stage_fetch
    import if_stage_fetch_pkg::*;
#(
    parameter int unsigned          AddressLen     = ADDRESS_LEN,
    parameter int unsigned          InstructionLen = INSTRUCTION_LEN,
    parameter logic [AddressLen-1:0] ResetPc       = '0,
    parameter int unsigned          PcStep         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      branch_taken,
    input  logic [AddressLen-1:0]     branch_address,
    output logic                      imem_req,
    output logic [AddressLen-1:0]     imem_addr,
    input  logic                      imem_ack,
    input  logic [InstructionLen-1:0] imem_rdata,
    output logic [AddressLen-1:0]     pc_out,
    output logic [InstructionLen-1:0] instruction_out,
    output logic                      valid_out
);

    localparam logic [AddressLen-1:0] Step = AddressLen'(PcStep);

    fetch_state_e              state_q, state_d;
    logic [AddressLen-1:0]     pc_q, pc_d;
    logic [AddressLen-1:0]     fetch_addr_q, fetch_addr_d;
    logic [AddressLen-1:0]     buf_pc_q, buf_pc_d;
    logic [InstructionLen-1:0] buf_instr_q, buf_instr_d;
    logic [AddressLen-1:0]     next_fetch;

    logic [AddressLen-1:0]     ifid_pc_d;
    logic [InstructionLen-1:0] ifid_instr_d;
    logic                      ifid_valid_d;

    assign next_fetch = fetch_addr_q + Step;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ifid_pc_d    = next_fetch;
        ifid_instr_d = InstructionLen'(BUBBLE_INSTR);
        ifid_valid_d = BUBBLE_VALID;
        imem_req     = 1'b0;

        case (state_q)
            StIdle: state_d = StReq;

            StReq: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d = branch_address;
                    if (imem_ack) begin
                        fetch_addr_d = branch_address;
                    end else begin
                        // Keep the outstanding address stable until its ack drains.
                        state_d = StDrop;
                    end
                end else if (imem_ack) begin
                    pc_d         = next_fetch;
                    fetch_addr_d = next_fetch;
                    if (freeze) begin
                        buf_pc_d    = next_fetch;
                        buf_instr_d = imem_rdata;
                        state_d     = StHold;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_valid_d = 1'b1;
                    end
                end
            end

            StHold: begin
                if (branch_taken) begin
                    pc_d         = branch_address;
                    fetch_addr_d = branch_address;
                    state_d      = StReq;
                end else if (!freeze) begin
                    ifid_pc_d    = buf_pc_q;
                    ifid_instr_d = buf_instr_q;
                    ifid_valid_d = 1'b1;
                    state_d      = StReq;
                end
            end

            StDrop: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d = branch_address;
                end
                if (imem_ack) begin
                    fetch_addr_d = pc_d;
                    state_d      = StReq;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            pc_q         <= ResetPc;
            fetch_addr_q <= ResetPc;
            buf_pc_q     <= '0;
            buf_instr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    assign imem_addr = fetch_addr_q;

    if_id_pipeline_reg #(
        .PcWidth   (AddressLen),
        .InstrWidth(InstructionLen)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_taken),
        .freeze_i(freeze),
        .pc_i    (ifid_pc_d),
        .instr_i (ifid_instr_d),
        .valid_i (ifid_valid_d),
        .pc_o    (pc_out),
        .instr_o (instruction_out),
        .valid_o (valid_out)
    );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a scoreboard of expected IF/ID contents.
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic        last_valid;

    if_stage_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Answer the current request; optionally record that its word must reach decode.
    task automatic ack_word(input bit expect_out);
        exp_t e;
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        if (expect_out) begin
            e.pc    = imem_addr + 32'd4;
            e.instr = word_of(imem_addr);
            exp_q.push_back(e);
        end
    endtask

    // One clock, then check IF/ID against the reset/flush/freeze model and the scoreboard.
    task automatic cycle();
        logic r, b, f;
        exp_t e;
        r = rst;
        b = branch_taken;
        f = freeze;
        @(posedge clk);
        #1;
        if (!r) begin
            chk("rst_pc_out", pc_out, 32'h0);
            chk("rst_instr", instruction_out, 32'h0);
            chk("rst_valid", 32'(valid_out), 32'h0);
            last_pc = '0; last_instr = '0; last_valid = 1'b0;
        end else if (b) begin
            chk("flush_valid", 32'(valid_out), 32'h0);
            chk("flush_instr", instruction_out, 32'h0);
            last_instr = '0; last_valid = 1'b0;
        end else if (f) begin
            chk("hold_valid", 32'(valid_out), 32'(last_valid));
            chk("hold_instr", instruction_out, last_instr);
            if (last_valid) chk("hold_pc", pc_out, last_pc);
        end else if (valid_out) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", pc_out, e.pc);
                chk("sb_instr", instruction_out, e.instr);
                last_pc = e.pc; last_instr = e.instr; last_valid = 1'b1;
            end
        end else begin
            chk("bubble_instr", instruction_out, 32'h0);
            last_instr = '0; last_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        last_pc = '0; last_instr = '0; last_valid = 1'b0;

        // Reset for two cycles, then release.
        cycle();
        cycle();
        chk("rst_req", 32'(imem_req), 32'h0);
        rst = 1'b1;
        cycle();
        chk("boot_req", 32'(imem_req), 32'h1);
        chk("boot_addr", imem_addr, 32'h0);

        // Zero-wait memory: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            ack_word(1'b1);
            cycle();
            chk("zw_valid", 32'(valid_out), 32'h1);
            chk("zw_pc", pc_out, 32'(i + 1) * 32'd4);
        end

        // Three wait states on address 0x10.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ws_addr", imem_addr, 32'h10);
            chk("ws_req", 32'(imem_req), 32'h1);
            chk("ws_valid", 32'(valid_out), 32'h0);
        end
        ack_word(1'b1);
        cycle();
        chk("ws_pc", pc_out, 32'h14);

        // Freeze in the ack cycle for 0x14, held two cycles.
        freeze = 1'b1;
        ack_word(1'b1);
        cycle();
        chk("frz_req", 32'(imem_req), 32'h0);
        chk("frz_pc", pc_out, 32'h14);
        imem_ack = 1'b0;
        cycle();
        chk("frz_req2", 32'(imem_req), 32'h0);
        freeze = 1'b0;
        cycle();
        chk("frz_rel_pc", pc_out, 32'h18);
        chk("frz_rel_req", 32'(imem_req), 32'h1);
        chk("frz_rel_addr", imem_addr, 32'h18);

        // Branch while 0x18 is outstanding; its late word must be dropped.
        cycle();
        branch_taken = 1'b1; branch_address = 32'h100;
        cycle();
        chk("br_req", 32'(imem_req), 32'h1);
        chk("br_old_addr", imem_addr, 32'h18);
        branch_taken = 1'b0;
        cycle();
        chk("drop_addr", imem_addr, 32'h18);
        imem_ack = 1'b1; imem_rdata = word_of(32'h18);
        cycle();
        chk("drop_valid", 32'(valid_out), 32'h0);
        chk("drop_new_addr", imem_addr, 32'h100);
        ack_word(1'b1);
        cycle();
        chk("br_pc", pc_out, 32'h104);

        // Branch, freeze and ack together: flush wins.
        branch_taken = 1'b1; branch_address = 32'h200; freeze = 1'b1;
        imem_ack = 1'b1; imem_rdata = word_of(32'h104);
        cycle();
        chk("bfa_addr", imem_addr, 32'h200);
        chk("bfa_req", 32'(imem_req), 32'h1);
        branch_taken = 1'b0; freeze = 1'b0; imem_ack = 1'b0;

        // Two branches during DROP: the later target wins.
        branch_taken = 1'b1; branch_address = 32'h300;
        cycle();
        branch_address = 32'h400;
        cycle();
        branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = word_of(32'h200);
        cycle();
        chk("latest_addr", imem_addr, 32'h400);
        chk("latest_valid", 32'(valid_out), 32'h0);
        imem_ack = 1'b0;

        // Reset while in DROP; a late ack after release is ignored.
        branch_taken = 1'b1; branch_address = 32'h500;
        cycle();
        branch_taken = 1'b0;
        chk("drop2_addr", imem_addr, 32'h400);
        rst = 1'b0;
        cycle();
        chk("rst_drop_req", 32'(imem_req), 32'h0);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = word_of(32'h400);
        cycle();
        chk("late_ack_req", 32'(imem_req), 32'h1);
        chk("late_ack_addr", imem_addr, 32'h0);
        chk("late_ack_valid", 32'(valid_out), 32'h0);

        // Address wrap at the top of the address space.
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC;
        imem_ack = 1'b1; imem_rdata = word_of(32'h0);
        cycle();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        ack_word(1'b1);
        cycle();
        chk("wrap_pc", pc_out, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        ack_word(1'b1);
        cycle();
        chk("post_wrap_pc", pc_out, 32'h4);
        imem_ack = 1'b0;
        cycle();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and runs a variable-latency req/ack handshake to instruction memory.
- Contains the IF/ID pipeline register, which supplies decode with next-PC (PC+4), instruction word and a valid flag.
- Honours the hazard freeze from the hazard unit and the branch redirect/flush from execute.

Parameters:
- ADDRESS_LEN, 32, PC and memory address width.
- INSTRUCTION_LEN, 32, instruction word width.
- RESET_PC, 32'h0, first fetch address after reset.
- PC_STEP, 4, byte increment per instruction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- freeze  in  1  hazard stall; holds the IF/ID register and the PC.
- branch_taken  in  1  redirect request from execute; flushes IF/ID.
- branch_address  in  ADDRESS_LEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDRESS_LEN  fetch address.
- imem_ack  in  1  fetch complete; imem_rdata is valid in this cycle.
- imem_rdata  in  INSTRUCTION_LEN  fetched word.
- pc_out  out  ADDRESS_LEN  fetch address + PC_STEP of the instruction in IF/ID.
- instruction_out  out  INSTRUCTION_LEN  instruction held in IF/ID; 0 for a bubble.
- valid_out  out  1  IF/ID holds a real instruction.

Behaviour:

Reset:
- While rst=0 at an edge: state=IDLE, pc=RESET_PC, fetch_addr=RESET_PC, imem_req=0, pc_out=0, instruction_out=0, valid_out=0, hold buffer cleared.
- Reset overrides every other input, including mid-transaction. Any ack that follows reset is ignored because imem_req=0.

States:
- IDLE: imem_req=0. Goes to REQ on the first edge after reset release.
- REQ: imem_req=1, imem_addr=fetch_addr.
- HOLD: imem_req=0. A fetched word is waiting in the hold buffer during freeze.
- DROP: imem_req=1 with the old fetch_addr. Waits for the ack of a request invalidated by a branch.

Transitions and actions:

REQ, ack=1, branch_taken=0:
- freeze=0: IF/ID <= {fetch_addr+PC_STEP, imem_rdata, 1}; pc and fetch_addr advance by PC_STEP; stay in REQ. imem_req may remain high back-to-back.
- freeze=1: hold buffer <= {fetch_addr+PC_STEP, imem_rdata}; pc advances; IF/ID unchanged; go to HOLD.

REQ, ack=0:
- freeze=0: IF/ID <= bubble (valid 0, instruction 0).
- freeze=1: IF/ID holds.
- imem_addr stays stable until ack.

REQ, branch_taken=1:
- ack=1: word discarded; pc = fetch_addr = branch_address; stay in REQ.
- ack=0: pc = branch_address; go to DROP; fetch_addr stays unchanged, so the outstanding address remains stable.

DROP:
- On ack: word discarded; fetch_addr <= pc; go to REQ.
- A further branch_taken in DROP updates pc only; the latest target wins.

HOLD:
- freeze=0: IF/ID <= {buffer, 1}; go to REQ.
- branch_taken=1: buffer discarded; pc = fetch_addr = branch_address; go to REQ.

Global rules:
- branch_taken has priority over freeze and ack. On any edge with branch_taken=1, IF/ID <= bubble.
- Latency: an ack in cycle N puts the instruction on the outputs after edge N. Zero-wait memory (ack tied 1) sustains 1 instruction/cycle.
- Address arithmetic is modulo 2^ADDRESS_LEN: 32'hFFFF_FFFC wraps to 0, and pc_out wraps the same way.
- At most one transaction is outstanding. The requester never drops imem_req before ack except on reset.

Decomposition:
- Shared package/defines holds:
  - ADDRESS_LEN and INSTRUCTION_LEN (these reuse the existing ADDRESS_LEN / INSTRUCTION_LEN defines).
  - Bubble encoding (all-zero instruction, valid 0).
  - 2-bit state encoding: IDLE=0, REQ=1, HOLD=2, DROP=3.
- One sub-module, if_id_pipeline_reg, holds pc/instruction/valid with flush (priority) and freeze inputs. It is reused later for the other inter-stage registers.

Test Plan:
1. rst=0 for 2 cycles, then release:
   - During reset: all outputs 0, imem_req=0.
   - One cycle after release: imem_req=1, imem_addr=0.
2. Zero-wait fetch: imem_ack tied 1, imem_rdata=addr^32'hA5A5_0000.
   - Consecutive cycles give pc_out=4,8,12 with matching instructions and valid_out=1 every cycle.
3. Wait states: ack asserted 3 cycles after req for addr 0x10.
   - imem_addr holds 0x10 throughout; valid_out=0 for those cycles.
   - Then pc_out=0x14 with the word.
4. freeze=1 in the ack cycle for addr 0x8, held 2 cycles:
   - IF/ID holds the 0x4 instruction; imem_req=0.
   - After release: pc_out=0xC with the 0x8 word, then req for 0xC.
5. Branch with outstanding request: req 0x20 pending, branch_taken to 0x100, ack 2 cycles later.
   - valid_out=0 after the branch edge; the 0x20 word never appears.
   - Next req addr=0x100; first valid pc_out=0x104.
6. branch_taken, freeze and ack in the same cycle:
   - Flush wins: valid_out=0; next imem_addr is the branch target.
   - Separately: asserting rst=0 while in DROP returns to IDLE, and a late ack produces no output.
